alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Buffered result stage directly downstream of the 32-bit combinational ALU. Captures each ALU result with its zero/carry_out/overflow flags and opcode through a valid/ready handshake. Holds results in a DEPTH-entry FIFO for the writeback consumer. Keeps sticky carry/overflow status bits and a saturating overflow-event counter for software and debug visibility.

## Interface
- DATA_W, 32, result width; must match the ALU result width
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CNT_W, 16, width of the overflow event counter
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ALU output is valid this cycle
- in_ready  output  1  stage can accept; equals !full, forced 0 while rst high
- in_opcode  input  3  opcode that produced the result
- in_result  input  DATA_W  ALU result
- in_zero, in_carry_out, in_overflow  input  1 each  ALU flags
- out_valid  output  1  head entry valid (!empty)
- out_ready  input  1  consumer accepts head entry
- out_opcode  output  3  head entry opcode
- out_result  output  DATA_W  head entry result
- out_zero, out_carry_out, out_overflow  output  1 each  head entry flags
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- clear_sticky  input  1  one-cycle pulse clears sticky status
- sticky_carry, sticky_overflow  output  1 each  set by any accepted entry with that flag
- ovf_count  output  CNT_W  number of accepted entries with overflow, saturating

## Operation
- Push is `in_valid && in_ready`. It writes {opcode, result, zero, carry_out, overflow} at the write pointer.
- Pop is `out_valid && out_ready`. It advances the read pointer.
- Pointers are $clog2(DEPTH)+1 bits wide with a wrap bit. Full means the indices are equal and the wrap bits differ. Empty means the pointers are equal. Indices wrap from DEPTH-1 to 0.
- Push and pop in the same cycle: both happen and level is unchanged. When full, in_ready is 0, so no push occurs and a pop frees one slot the next cycle. When empty, out_valid is 0, so no pop occurs.
- There is no bypass. An entry pushed into an empty FIFO becomes visible one cycle later.
- The out_* fields come from the head entry. They must stay stable while out_valid is high and out_ready is low.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.
- Sticky bits: on push, sticky_carry |= in_carry_out and sticky_overflow |= in_overflow.
  - clear_sticky zeroes both bits.
  - If clear_sticky and a flagged push happen in the same cycle, the set wins.
- ovf_count increments on each push with in_overflow=1. It holds at all-ones (2^CNT_W-1). clear_sticky also zeroes it, and a same-cycle overflow push leaves it at 1.
- Flags are stored exactly as delivered. The stage does not reinterpret them by opcode.

## Timing
- Reset (rst high at a clock edge) sets:
  - pointers = 0, level = 0, out_valid = 0, in_ready = 0 while rst is asserted
  - out_result = 0, out_opcode = 0, all out_* flags = 0
  - sticky_carry = 0, sticky_overflow = 0, ovf_count = 0
- in_ready rises in the first cycle after rst deasserts.
- Reset mid-operation discards all stored entries. Pushes and pops presented in the reset cycle are ignored.
- Latency from push to out_valid is 1 cycle. A full-rate stream (one push and one pop per cycle) sustains 1 entry/cycle at any level from 1 to DEPTH-1.
- level, sticky bits and ovf_count update on the same edge as the push or pop that changes them.
- Storage array needs no reset. Out_* data comes from a registered/muxed head entry and reads 0 after reset until the first push.

## Structure
- The shared package `alu_pkg` holds:
  - opcode constants OP_ADD=3'b000 through OP_PASS=3'b111
  - the `alu_result_t` struct {opcode, result, zero, carry_out, overflow}
  - DATA_W default
- One sub-module, `alu_result_fifo`: a generic parameterized sync FIFO with valid/ready and level output.
- The top level adds the sticky status logic and ovf_count around `alu_result_fifo`.

## Test plan
- Reset, then push ADD result 0x0000_0000 with zero=1, out_ready=1:
  - out_valid is high 1 cycle after the push with out_result=0, out_zero=1
  - level returns to 0 after the pop
- Push 5 entries (0x1..0x5) with out_ready=0 and DEPTH=4:
  - in_ready drops after the 4th push and level=4
  - the 5th entry is not accepted
  - draining yields 0x1..0x4 in order, then out_valid=0
- Continuous stream of 100 entries with in_valid=1 and out_ready=1:
  - 1 entry/cycle throughput with no loss or reordering
  - out data holds stable under random out_ready stalls
- Push ADD with overflow=1 (0x7FFF_FFFF+1, result 0x8000_0000):
  - sticky_overflow=1, ovf_count=1
  - a clear_sticky in the same cycle as a second overflow push leaves sticky_overflow=1, ovf_count=1
- With CNT_W=4, push 20 overflow entries: ovf_count saturates at 15. Then pulse clear_sticky with no push: ovf_count=0 and both sticky bits=0.
- Assert rst with level=3 and in_valid=1:
  - next cycle level=0, out_valid=0, all status bits 0
  - in_ready=0 during reset and 1 the cycle after deassert

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its downstream result stage:
// opcode encodings, the default datapath width and the captured-result record.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry_out;
    logic              overflow;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides and an occupancy output.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module alu_result_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !rst;
  assign level     = wr_ptr - rd_ptr;

  // Pointer update; power-of-two depth lets the increment wrap index and toggle the wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Head entry, masked to zero while empty so stale storage never reaches the consumer.
  always_comb begin
    out_data = {WIDTH{1'b0}};
    if (empty) begin
      out_data = {WIDTH{1'b0}};
    end else begin
      out_data = mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Buffered ALU result stage: FIFO of {opcode, result, flags} for writeback, plus
// sticky carry/overflow status and a saturating overflow-event counter.
module alu_result_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_opcode,
  input  logic [DATA_W-1:0]       in_result,
  input  logic                    in_zero,
  input  logic                    in_carry_out,
  input  logic                    in_overflow,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_opcode,
  output logic [DATA_W-1:0]       out_result,
  output logic                    out_zero,
  output logic                    out_carry_out,
  output logic                    out_overflow,
  output logic [$clog2(DEPTH):0]  level,
  input  logic                    clear_sticky,
  output logic                    sticky_carry,
  output logic                    sticky_overflow,
  output logic [CNT_W-1:0]        ovf_count
);

  import alu_pkg::*;

  localparam int              ENTRY_W = DATA_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic               push;
  logic               ovf_push;

  // Same field order as alu_result_t so the packed entry maps onto the record.
  assign in_entry = {in_opcode, in_result, in_zero, in_carry_out, in_overflow};
  assign {out_opcode, out_result, out_zero, out_carry_out, out_overflow} = out_entry;

  assign push     = in_valid && in_ready;
  assign ovf_push = push && in_overflow;

  alu_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry),
    .level     (level)
  );

  // Status: a flagged push in the same cycle as clear_sticky takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
      ovf_count       <= {CNT_W{1'b0}};
    end else begin
      sticky_carry    <= (sticky_carry & ~clear_sticky) | (push & in_carry_out);
      sticky_overflow <= (sticky_overflow & ~clear_sticky) | ovf_push;
      if (clear_sticky) begin
        ovf_count <= ovf_push ? CNT_ONE : {CNT_W{1'b0}};
      end else if (ovf_push && (ovf_count != CNT_MAX)) begin
        ovf_count <= ovf_count + CNT_ONE;
      end else begin
        ovf_count <= ovf_count;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (DEPTH=4, CNT_W=4): directed scenarios plus random traffic.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [31:0] in_result;
  logic        in_zero, in_carry_out, in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [31:0] out_result;
  logic        out_zero, out_carry_out, out_overflow;
  logic [2:0]  level;
  logic        clear_sticky;
  logic        sticky_carry, sticky_overflow;
  logic [CNT_W-1:0] ovf_count;

  int checks = 0;
  int errors = 0;

  alu_result_t exp_q[$];
  int  exp_level = 0;
  bit  exp_sc = 1'b0;
  bit  exp_so = 1'b0;
  int  exp_cnt = 0;
  bit  fresh_empty = 1'b1;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_result(in_result),
    .in_zero(in_zero), .in_carry_out(in_carry_out), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_result(out_result),
    .out_zero(out_zero), .out_carry_out(out_carry_out), .out_overflow(out_overflow),
    .level(level), .clear_sticky(clear_sticky),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow), .ovf_count(ovf_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_result_t in_rec();
    alu_result_t r;
    r.opcode = in_opcode; r.result = in_result;
    r.zero = in_zero; r.carry_out = in_carry_out; r.overflow = in_overflow;
    return r;
  endfunction

  function automatic alu_result_t out_rec();
    alu_result_t r;
    r.opcode = out_opcode; r.result = out_result;
    r.zero = out_zero; r.carry_out = out_carry_out; r.overflow = out_overflow;
    return r;
  endfunction

  // Reference model: occupancy, status and expected-entry queue, checked at every falling edge.
  initial begin
    bit exp_ready, push, pop, ovf_push;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = !rst && (exp_level < DEPTH);
      check("in_ready", in_ready, exp_ready);
      check("level", level, exp_level);
      check("out_valid", out_valid, exp_level != 0);
      check("sticky_carry", sticky_carry, exp_sc);
      check("sticky_overflow", sticky_overflow, exp_so);
      check("ovf_count", ovf_count, exp_cnt);
      if (fresh_empty) check("out_zeroed", out_rec(), 0);
      if (rst) begin
        exp_q.delete();
        exp_level = 0; exp_sc = 1'b0; exp_so = 1'b0; exp_cnt = 0; fresh_empty = 1'b1;
      end else begin
        push = in_valid && exp_ready;
        pop  = out_ready && (exp_level != 0);
        ovf_push = push && in_overflow;
        if (push) begin
          exp_q.push_back(in_rec());
          fresh_empty = 1'b0;
        end
        exp_level = exp_level + int'(push) - int'(pop);
        exp_sc = (clear_sticky ? 1'b0 : exp_sc) | (push && in_carry_out);
        exp_so = (clear_sticky ? 1'b0 : exp_so) | ovf_push;
        if (clear_sticky) exp_cnt = ovf_push ? 1 : 0;
        else if (ovf_push && exp_cnt < CNT_SAT) exp_cnt = exp_cnt + 1;
      end
    end
  end

  // Output monitor: pops the scoreboard on each consumer handshake and checks head stability.
  initial begin
    alu_result_t held, cur, exp;
    bit hold = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cur = out_rec();
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold && out_valid) check("out_stable", cur, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pop", 1'b1, 1'b0);
          end else begin
            exp = exp_q.pop_front();
            check("out_data", cur, exp);
          end
        end
        hold = out_valid && !out_ready;
        held = cur;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] res,
                       input bit z, input bit c, input bit o);
    in_valid = v; in_opcode = op; in_result = res;
    in_zero = z; in_carry_out = c; in_overflow = o;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    check("drain_bound", n < 20, 1'b1);
  endtask

  initial begin
    logic [31:0] a, b;
    int acc;
    rst = 1'b1; out_ready = 1'b0; clear_sticky = 1'b0;
    drive(1'b0, OP_ADD, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Single zero result through an empty FIFO
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_zero", out_zero, 1'b1);
    step();
    check("t1_level_after_pop", level, 3'd0);

    // Overfill with the consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, OP_PASS, 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    check("fill_level", level, 3'd4);
    check("fill_in_ready", in_ready, 1'b0);
    drain();
    check("drain_empty", out_valid, 1'b0);

    // Full-rate stream
    acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      acc += int'(in_ready);
      step();
    end
    check("stream_rate", acc, 100);
    drain();

    // Random traffic with consumer stalls and occasional clears
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 9) < 6);
      clear_sticky = ($urandom_range(0, 15) == 0);
      step();
    end
    clear_sticky = 1'b0;
    drain();

    // Signed overflow from 0x7FFF_FFFF + 1, then clear racing a second overflow push
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    a = 32'h7FFF_FFFF; b = 32'h0000_0001;
    drive(1'b1, OP_ADD, a + b, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("ovf_sticky", sticky_overflow, 1'b1);
    check("ovf_count_1", ovf_count, 4'd1);
    drive(1'b1, OP_ADD, a + b, 1'b0, 1'b0, 1'b1);
    clear_sticky = 1'b1;
    step();
    in_valid = 1'b0; clear_sticky = 1'b0;
    check("clr_race_sticky", sticky_overflow, 1'b1);
    check("clr_race_count", ovf_count, 4'd1);

    // Counter saturation, then a bare clear
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, OP_SUB, $urandom, 1'b0, 1'b1, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check("ovf_saturate", ovf_count, 4'd15);
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    check("clear_count", ovf_count, 4'd0);
    check("clear_sc", sticky_carry, 1'b0);
    check("clear_so", sticky_overflow, 1'b0);
    drain();

    // Reset with three entries held and a push pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_XOR, $urandom, 1'b0, 1'b1, 1'b1);
      step();
    end
    check("pre_rst_level", level, 3'd3);
    rst = 1'b1; out_ready = 1'b1;
    step();
    check("rst_level", level, 3'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_status", {sticky_carry, sticky_overflow, ovf_count}, 6'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
